immediate_encode_loader: RTL and testbench

//  Inverse of the datapath immediate sign-extender: packs opcode/func/rs/rt and a 32-bit

---
 rtl/immediate_encode_loader.sv | 203 ++++++++++++++++++++
 tb/tb_immediate_encode_loader.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/immediate_encode_loader.sv
// ---------------------------------------------------------------------------
// immediate_encode_loader
//
// Purpose:
//   Packs an opcode, register fields and a 32-bit signed immediate into one
//   32-bit instruction word and writes it to the instruction memory. This is
//   the inverse of the datapath sign-extender. The immediate is range-checked
//   against the width of the field the decoder will later sign-extend.
//   Sits between the testbench/boot loader and the instruction memory write
//   port.
//
// Build option:
//   IMM_SATURATE_EN - when defined, an out-of-range immediate is clamped to
//                     the field min/max and written normally. It still
//                     raises err and is counted. When undefined, an
//                     out-of-range request is dropped with err and nothing
//                     is written.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   clr        in   synchronous restart: address back to BASE_ADDR, back to idle
//   in_valid   in   request valid
//   in_ready   out  a request can be accepted this cycle
//   opcode     in   instr[31:26]
//   func       in   function field, used by the shift format only
//   rs         in   instr[25:21]
//   rt         in   instr[20:16]
//   imm        in   signed immediate to encode
//   mem_we     out  instruction memory write enable (1-cycle pulse)
//   mem_addr   out  instruction memory word address
//   mem_wdata  out  encoded instruction word
//   err        out  1-cycle pulse: immediate out of range
//   err_count  out  saturating count of err pulses
//   full       out  last address has been written; no more requests taken
// ---------------------------------------------------------------------------
module immediate_encode_loader #(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [4:0]        func,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err,
  output logic [7:0]        err_count,
  output logic              full
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, FULL} state_t;

  localparam logic [5:0]        OP_SHIFT  = 6'b000010;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state, state_next;
  logic [5:0]        op_q;
  logic [4:0]        func_q, rs_q, rt_q;
  logic [31:0]       imm_q;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              err_q;
  logic [7:0]        errcnt;
  logic              clr_pend;
  logic              transfer;
  logic              clr_any;
  logic              is_shift;
  logic              imm_legal;
  logic              do_write;
  logic [4:0]        field5;
  logic [15:0]       field16;
  logic [31:0]       word;

  assign transfer = in_valid && in_ready;
  // A clr seen while a request is in flight is remembered in clr_pend and
  // honoured on the way back to IDLE, so the in-flight write is never lost.
  assign clr_any  = clr || clr_pend;

  // Range check and encoding of the captured request. Evaluated during
  // CHECK; the result is registered into wdata/err at the end of CHECK.
  // An immediate fits an n-bit signed field when every bit above the
  // field's sign bit equals imm[31].
  always_comb begin
    is_shift  = (op_q == OP_SHIFT);
    imm_legal = is_shift ? (imm_q[31:4]  == {28{imm_q[31]}})
                         : (imm_q[31:15] == {17{imm_q[31]}});
`ifdef IMM_SATURATE_EN
    // Clamp towards the sign of the original value.
    field5  = imm_legal ? imm_q[4:0]  : (imm_q[31] ? 5'b10000 : 5'b01111);
    field16 = imm_legal ? imm_q[15:0] : (imm_q[31] ? 16'h8000 : 16'h7FFF);
    do_write = 1'b1;
`else
    field5   = imm_q[4:0];
    field16  = imm_q[15:0];
    do_write = imm_legal;
`endif
    word = is_shift ? {op_q, rs_q, rt_q, field5, 6'b000000, func_q}
                    : {op_q, rs_q, rt_q, field16};
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic. A write at the last address parks the block in FULL
  // (no wrap) unless a clr is pending, in which case we restart instead.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (transfer) state_next = CHECK;
      CHECK: state_next = do_write ? WRITE : IDLE;
      WRITE: state_next = (!clr_any && addr == LAST_ADDR) ? FULL : IDLE;
      FULL:  if (clr) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode. in_ready is held low during reset and whenever clr is
  // asserted, so clr always beats a simultaneous in_valid.
  always_comb begin
    mem_we   = (state == WRITE);
    full     = (state == FULL);
    in_ready = rst && (state == IDLE) && !clr;
  end

  // Latched clr: set while a request is in flight, dropped when we return
  // to IDLE (which is where it takes effect).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                           clr_pend <= 1'b0;
    else if (state_next == IDLE)                        clr_pend <= 1'b0;
    else if (clr && (state == CHECK || state == WRITE)) clr_pend <= 1'b1;
  end

  // Write address. Advances only after a real write, restarts on clr, and
  // holds at the last address once FULL is reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= BASE_ADDR;
    end else begin
      case (state)
        IDLE, FULL: if (clr) addr <= BASE_ADDR;
        CHECK:      if (!do_write && clr_any) addr <= BASE_ADDR;
        WRITE: begin
          if (clr_any)                addr <= BASE_ADDR;
          else if (addr != LAST_ADDR) addr <= addr + ADDR_W'(1);
        end
        default: addr <= addr;
      endcase
    end
  end

  // Request capture on the transfer edge, so the caller is free to change
  // its inputs afterwards. The encoded word is registered at the end of
  // CHECK and stays stable through WRITE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= '0;
      func_q <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      imm_q  <= '0;
      wdata  <= '0;
    end else begin
      if (transfer) begin
        op_q   <= opcode;
        func_q <= func;
        rs_q   <= rs;
        rt_q   <= rt;
        imm_q  <= imm;
      end
      if (state == CHECK && do_write) wdata <= word;
    end
  end

  // Error pulse and its saturating counter, both decided at the end of
  // CHECK so err is high for exactly the cycle after CHECK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q  <= 1'b0;
      errcnt <= '0;
    end else begin
      err_q <= (state == CHECK) && !imm_legal;
      if (state == CHECK && !imm_legal && errcnt != 8'hFF)
        errcnt <= errcnt + 8'd1;
    end
  end

  assign mem_addr  = addr;
  assign mem_wdata = wdata;
  assign err       = err_q;
  assign err_count = errcnt;

endmodule

// File: tb/tb_immediate_encode_loader.sv
// ---------------------------------------------------------------------------
// tb_immediate_encode_loader
//
// Self-checking bench for immediate_encode_loader built with ADDR_W=2 so
// the FULL boundary is reachable quickly. Expected memory writes are pushed
// to a scoreboard queue when a request is issued and popped by a monitor
// whenever mem_we is seen. Scenario tasks check err, err_count, handshake
// and address behaviour inline. Expectations follow IMM_SATURATE_EN when it
// is defined.
// ---------------------------------------------------------------------------
module tb_immediate_encode_loader;

  localparam int AW = 2;
`ifdef IMM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [5:0]    opcode = '0;
  logic [4:0]    func = '0, rs = '0, rt = '0;
  logic [31:0]   imm = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          err;
  logic [7:0]    err_count;
  logic          full;

  int  checks = 0;
  int  fails  = 0;
  wr_t sb[$];
  int  exp_addr = 0;
  bit  exp_full = 1'b0;
  int  exp_errs = 0;

  immediate_encode_loader #(.ADDR_W(AW), .BASE_ADDR(2'b00)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func(func), .rs(rs), .rt(rt), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .err(err), .err_count(err_count), .full(full)
  );

  always #5 clk = ~clk;

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model of the encoder, written from the instruction formats.
  function automatic bit model_legal(input logic [5:0] op, input int v);
    if (op == 6'h02) return (v >= -16 && v <= 15);
    return (v >= -32768 && v <= 32767);
  endfunction

  function automatic logic [31:0] model_word(input logic [5:0] op, input logic [4:0] fn,
                                             input logic [4:0] s, input logic [4:0] t,
                                             input int v);
    int c;
    logic [31:0] u;
    c = v;
    if (SAT) begin
      if (op == 6'h02) begin
        if (c > 15)  c = 15;
        if (c < -16) c = -16;
      end else begin
        if (c > 32767)  c = 32767;
        if (c < -32768) c = -32768;
      end
    end
    u = c;
    if (op == 6'h02) return {op, s, t, u[4:0], 6'b000000, fn};
    return {op, s, t, u[15:0]};
  endfunction

  // Records the expected outcome of one accepted request in the model.
  task automatic model_accept(input logic [5:0] op, input logic [4:0] fn,
                              input logic [4:0] s, input logic [4:0] t, input int v);
    wr_t e;
    bit  ok;
    ok = model_legal(op, v);
    if (ok || SAT) begin
      e.addr = exp_addr[AW-1:0];
      e.data = model_word(op, fn, s, t, v);
      sb.push_back(e);
      if (exp_addr == (1 << AW) - 1) exp_full = 1'b1;
      else                           exp_addr++;
    end
    if (!ok) exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
  endtask

  // Issues one request and returns #1 after its transfer edge (CHECK cycle).
  task automatic applyStimulus(input logic [5:0] op, input logic [4:0] fn,
                               input logic [4:0] s, input logic [4:0] t,
                               input int v, output bit legal);
    int waited;
    if (exp_full) begin
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      exp_addr = 0;
      exp_full = 1'b0;
    end
    #1;
    opcode = op; func = fn; rs = s; rt = t; imm = v;
    in_valid = 1'b1;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL handshake_timeout: in_ready=%b required 1", in_ready);
    end
    legal = model_legal(op, v);
    model_accept(op, fn, s, t, v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode = 6'($urandom); func = 5'($urandom); rs = 5'($urandom);
    rt = 5'($urandom); imm = $urandom;
  endtask

  // Scoreboard monitor: every write must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && mem_we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_write: addr=%0d data=%h, none expected", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          fails++;
          $display("[TB] FAIL write_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    #3;
    checks += 7;
    if (mem_we !== 1'b0)     begin fails++; $display("[TB] FAIL reset_we: got %b want 0", mem_we); end
    if (mem_addr !== 2'd0)   begin fails++; $display("[TB] FAIL reset_addr: got %0d want 0", mem_addr); end
    if (mem_wdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_wdata: got %h want 0", mem_wdata); end
    if (err !== 1'b0)        begin fails++; $display("[TB] FAIL reset_err: got %b want 0", err); end
    if (err_count !== 8'h0)  begin fails++; $display("[TB] FAIL reset_errcnt: got %0d want 0", err_count); end
    if (full !== 1'b0)       begin fails++; $display("[TB] FAIL reset_full: got %b want 0", full); end
    if (in_ready !== 1'b0)   begin fails++; $display("[TB] FAIL reset_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL ready_after_reset: got %b want 1", in_ready); end
  endtask

  task automatic test_encode_itype();
    bit l;
    applyStimulus(6'h08, 5'h00, 5'd1, 5'd2, -5, l);
    checks++;
    if (mem_we !== 1'b0) begin fails++; $display("[TB] FAIL itype_latency_early: mem_we=%b want 0", mem_we); end
    @(posedge clk); #1;
    checks += 4;
    if (mem_we !== 1'b1)            begin fails++; $display("[TB] FAIL itype_we: got %b want 1", mem_we); end
    if (mem_addr !== 2'd0)          begin fails++; $display("[TB] FAIL itype_addr: got %0d want 0", mem_addr); end
    if (mem_wdata !== 32'h2022FFFB) begin fails++; $display("[TB] FAIL itype_word: got %h want 2022fffb", mem_wdata); end
    if (err !== 1'b0)               begin fails++; $display("[TB] FAIL itype_err: got %b want 0", err); end
    @(posedge clk); #1;
    checks += 2;
    if (mem_we !== 1'b0)   begin fails++; $display("[TB] FAIL itype_we_pulse: got %b want 0", mem_we); end
    if (mem_addr !== 2'd1) begin fails++; $display("[TB] FAIL itype_addr_inc: got %0d want 1", mem_addr); end
  endtask

  task automatic test_encode_shift();
    bit l;
    applyStimulus(6'h02, 5'h03, 5'd3, 5'd4, 7, l);
    @(posedge clk); #1;
    checks += 2;
    if (mem_we !== 1'b1)            begin fails++; $display("[TB] FAIL shift_we: got %b want 1", mem_we); end
    if (mem_wdata !== 32'h08643803) begin fails++; $display("[TB] FAIL shift_word: got %h want 08643803", mem_wdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_range_error();
    bit l;
    applyStimulus(6'h02, 5'h01, 5'd0, 5'd0, 16, l);
    @(posedge clk); #1;
    checks += 3;
    if (err !== 1'b1)       begin fails++; $display("[TB] FAIL range_err: got %b want 1", err); end
    if (err_count !== 8'd1) begin fails++; $display("[TB] FAIL range_errcnt: got %0d want 1", err_count); end
    if (mem_we !== SAT)     begin fails++; $display("[TB] FAIL range_we: got %b want %b", mem_we, SAT); end
    @(posedge clk); #1;
    checks += 2;
    if (err !== 1'b0) begin fails++; $display("[TB] FAIL range_err_pulse: got %b want 0", err); end
    if (mem_addr !== exp_addr[AW-1:0])
      begin fails++; $display("[TB] FAIL range_addr: got %0d want %0d", mem_addr, exp_addr); end
  endtask

  task automatic test_boundaries();
    logic [5:0] ops[10] = '{6'h08, 6'h08, 6'h08, 6'h08, 6'h02, 6'h02, 6'h02, 6'h02, 6'h23, 6'h02};
    int         vals[10] = '{32767, -32768, 32768, -32769, 15, -16, -17, 100000, -1, -1};
    bit l;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(ops[i], 5'(i), 5'(i + 3), 5'(31 - i), vals[i], l);
      @(posedge clk); #1;
      checks += 3;
      if (err !== !l) begin fails++; $display("[TB] FAIL bound_err[%0d]: got %b want %b", i, err, !l); end
      if (err_count !== exp_errs[7:0])
        begin fails++; $display("[TB] FAIL bound_errcnt[%0d]: got %0d want %0d", i, err_count, exp_errs); end
      if (mem_we !== (l || SAT))
        begin fails++; $display("[TB] FAIL bound_we[%0d]: got %b want %b", i, mem_we, l || SAT); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full();
    bit l;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_addr = 0; exp_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(6'h0D, 5'd0, 5'(i), 5'(i + 1), i * 1000 - 1500, l);
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    checks += 3;
    if (full !== 1'b1)     begin fails++; $display("[TB] FAIL full_flag: got %b want 1", full); end
    if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL full_ready: got %b want 0", in_ready); end
    if (mem_addr !== 2'd3) begin fails++; $display("[TB] FAIL full_addr_hold: got %0d want 3", mem_addr); end
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    clr = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL full_clr_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    #1;
    exp_addr = 0; exp_full = 1'b0;
    checks += 3;
    if (full !== 1'b0)     begin fails++; $display("[TB] FAIL clr_full: got %b want 0", full); end
    if (mem_addr !== 2'd0) begin fails++; $display("[TB] FAIL clr_addr: got %0d want 0", mem_addr); end
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL clr_ready: got %b want 1", in_ready); end
    applyStimulus(6'h08, 5'd0, 5'd7, 5'd8, 42, l);
    @(posedge clk); #1;
    checks++;
    if (mem_addr !== 2'd0) begin fails++; $display("[TB] FAIL after_clr_addr: got %0d want 0", mem_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_clr_with_valid();
    opcode = 6'h08; imm = 32'd9;
    in_valid = 1'b1;
    clr = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL clr_valid_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0;
    exp_addr = 0; exp_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 2;
    if (mem_addr !== 2'd0) begin fails++; $display("[TB] FAIL clr_valid_addr: got %0d want 0", mem_addr); end
    if (sb.size() != 0)    begin fails++; $display("[TB] FAIL clr_valid_pending: got %0d want 0", sb.size()); end
  endtask

  task automatic test_clr_inflight();
    bit l;
    applyStimulus(6'h08, 5'd0, 5'd1, 5'd1, 11, l);
    @(posedge clk); #1;
    @(posedge clk); #1;
    applyStimulus(6'h08, 5'd0, 5'd2, 5'd2, -22, l);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks += 2;
    if (mem_we !== 1'b1)   begin fails++; $display("[TB] FAIL inflight_we: got %b want 1", mem_we); end
    if (mem_addr !== 2'd1) begin fails++; $display("[TB] FAIL inflight_addr: got %0d want 1", mem_addr); end
    @(posedge clk); #1;
    exp_addr = 0; exp_full = 1'b0;
    checks += 2;
    if (mem_addr !== 2'd0) begin fails++; $display("[TB] FAIL inflight_clr_addr: got %0d want 0", mem_addr); end
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL inflight_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      opcode = 6'h09; func = 5'd0; rs = 5'(i); rt = 5'(i + 10); imm = i * 100 - 300;
      #1;
      checks++;
      if (in_ready !== (i % 3 == 0))
        begin fails++; $display("[TB] FAIL b2b_ready[%0d]: got %b want %b", i, in_ready, i % 3 == 0); end
      if (i % 3 == 0) model_accept(6'h09, 5'd0, 5'(i), 5'(i + 10), i * 100 - 300);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (sb.size() != 0) begin fails++; $display("[TB] FAIL b2b_pending: got %0d want 0", sb.size()); end
  endtask

  task automatic test_err_saturate();
    bit l;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(6'h08, 5'd0, 5'd0, 5'd0, 40000 + i, l);
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    checks++;
    if (err_count !== 8'hFF) begin fails++; $display("[TB] FAIL err_saturate: got %0d want 255", err_count); end
  endtask

  task automatic test_reset_in_write();
    bit  l;
    wr_t dropped;
    applyStimulus(6'h08, 5'd0, 5'd5, 5'd6, 77, l);
    dropped = sb.pop_back();
    @(posedge clk); #1;
    checks++;
    if (mem_we !== 1'b1) begin fails++; $display("[TB] FAIL rstwr_we_before: got %b want 1", mem_we); end
    rst = 1'b0;
    #1;
    checks += 4;
    if (mem_we !== 1'b0)    begin fails++; $display("[TB] FAIL rstwr_we: got %b want 0", mem_we); end
    if (mem_addr !== 2'd0)  begin fails++; $display("[TB] FAIL rstwr_addr: got %0d want 0", mem_addr); end
    if (err_count !== 8'h0) begin fails++; $display("[TB] FAIL rstwr_errcnt: got %0d want 0", err_count); end
    if (in_ready !== 1'b0)  begin fails++; $display("[TB] FAIL rstwr_ready: got %b want 0", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_addr = 0; exp_full = 1'b0; exp_errs = 0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (mem_addr !== 2'd0) begin fails++; $display("[TB] FAIL rstwr_addr_after: got %0d want 0", mem_addr); end
  endtask

  initial begin
    test_reset();
    test_encode_itype();
    test_encode_shift();
    test_range_error();
    test_boundaries();
    test_full();
    test_clr_with_valid();
    test_clr_inflight();
    test_back_to_back();
    test_err_saturate();
    test_reset_in_write();
    checks++;
    if (sb.size() != 0) begin fails++; $display("[TB] FAIL scoreboard_drain: %0d writes never seen, want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
